// File: rtl/timer_poll_ctrl.sv
// Bus master for the timer32 slave: programs period/control, polls status continuously,
// and counts both edges of one status bit into a wrapping counter with a one-cycle pulse.
module timer_poll_ctrl #(
  parameter logic [31:0] PERIOD   = 32'h005F5E10,
  parameter logic [31:0] CTRL_ON  = 32'h00000001,
  parameter int unsigned POLL_BIT = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [1:0]       addr,
  output logic [31:0]      din,
  output logic             wren,
  output logic             rden,
  input  logic [31:0]      dout,
  output logic             toggle_pulse,
  output logic [CNT_W-1:0] event_count
);

  localparam int unsigned IDX_W    = 5;
  localparam logic [IDX_W-1:0] POLL_IDX = IDX_W'(POLL_BIT);
  localparam logic [1:0] A_CTRL   = 2'b00;
  localparam logic [1:0] A_PERIOD = 2'b01;
  localparam logic [1:0] A_STATUS = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PERIOD,
    S_WR_CTRL,
    S_POLL,
    S_WR_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_addr;
  logic [31:0]      r_din;
  logic             r_wren;
  logic             r_rden;
  logic             r_busy;
  logic [1:0]       w_addr_nxt;
  logic [31:0]      w_din_nxt;
  logic             w_wren_nxt;
  logic             w_rden_nxt;
  logic             w_busy_nxt;

  logic             r_sample_valid;
  logic             r_have_base;
  logic             r_prev_bit;
  logic             r_toggle;
  logic [CNT_W-1:0] r_count;
  logic             w_bit;
  logic             w_start_accept;
  logic             w_unused;

  assign w_bit          = dout[POLL_IDX];
  assign w_start_accept = (r_state == S_IDLE) && start;
  assign w_unused       = ^dout;

  // Next state, and the bus drive that the next state will present; registering it keeps
  // the bus a pure function of the state register with no path from start/stop/dout.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = A_CTRL;
    w_din_nxt   = 32'h0;
    w_wren_nxt  = 1'b0;
    w_rden_nxt  = 1'b0;
    w_busy_nxt  = 1'b1;
    unique case (r_state)
      S_IDLE:      if (start) w_state_nxt = S_WR_PERIOD;
      S_WR_PERIOD: w_state_nxt = stop ? S_WR_STOP : S_WR_CTRL;
      S_WR_CTRL:   w_state_nxt = stop ? S_WR_STOP : S_POLL;
      S_POLL:      if (stop) w_state_nxt = S_WR_STOP;
      S_WR_STOP:   w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
    unique case (w_state_nxt)
      S_IDLE:      w_busy_nxt = 1'b0;
      S_WR_PERIOD: begin
        w_addr_nxt = A_PERIOD;
        w_din_nxt  = PERIOD;
        w_wren_nxt = 1'b1;
      end
      S_WR_CTRL: begin
        w_addr_nxt = A_CTRL;
        w_din_nxt  = CTRL_ON;
        w_wren_nxt = 1'b1;
      end
      S_POLL: begin
        w_addr_nxt = A_STATUS;
        w_rden_nxt = 1'b1;
      end
      S_WR_STOP:   w_wren_nxt = 1'b1;
      default:     w_busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= 2'b00;
      r_din   <= 32'h0;
      r_wren  <= 1'b0;
      r_rden  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      r_wren  <= w_wren_nxt;
      r_rden  <= w_rden_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Read data returns one cycle after rden, so samples lag POLL by one cycle (incl. into WR_STOP).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample_valid <= 1'b0;
      r_have_base    <= 1'b0;
      r_prev_bit     <= 1'b0;
      r_toggle       <= 1'b0;
      r_count        <= '0;
    end else begin
      r_sample_valid <= (r_state == S_POLL);
      r_toggle       <= 1'b0;
      if (w_start_accept) begin
        r_count     <= '0;
        r_have_base <= 1'b0;
      end else if (r_sample_valid) begin
        if (!r_have_base) begin
          r_prev_bit  <= w_bit;
          r_have_base <= 1'b1;
        end else if (w_bit != r_prev_bit) begin
          r_toggle   <= 1'b1;
          r_count    <= r_count + CNT_W'(1);
          r_prev_bit <= w_bit;
        end
      end
    end
  end

  assign busy         = r_busy;
  assign addr         = r_addr;
  assign din          = r_din;
  assign wren         = r_wren;
  assign rden         = r_rden;
  assign toggle_pulse = r_toggle;
  assign event_count  = r_count;

endmodule

// File: doc/timer_poll_ctrl.md
Name: timer_poll_ctrl

Overview:
Bus master that sits directly on the timer32 slave bus (clk, addr[1:0], din, dout, wren, rden) in place of the tied-off constants in the board top level. On start it programs the timer's period and control registers, then polls the status register continuously. It detects toggles of one status bit, emitting a one-cycle pulse and a running event count for LED/downstream logic. On stop it disables the timer and returns to idle.

Parameters:
PERIOD, 32'h005F5E10, value written to timer period register (addr 2'b01)
CTRL_ON, 32'h00000001, value written to timer control register (addr 2'b00) to enable counting
POLL_BIT, 2, bit index of status word (addr 2'b10) whose toggles are counted; legal 0..31
CNT_W, 8, width of event_count

Ports:
clk  input  1  system clock (50 MHz from clk_wiz)
reset  input  1  asynchronous, active-low reset
start  input  1  level/pulse; begins programming sequence when sampled high in IDLE
stop  input  1  level/pulse; aborts/ends operation when sampled high in any non-IDLE state
busy  output  1  high in every state except IDLE
addr  output  2  timer bus address
din  output  32  write data to timer (timer's din)
wren  output  1  timer write strobe
rden  output  1  timer read strobe
dout  input  32  read data from timer (timer's dout); valid the cycle after rden
toggle_pulse  output  1  one-cycle pulse per detected POLL_BIT edge
event_count  output  CNT_W  number of detected edges since last start

Behaviour:
- reset low (async): state=IDLE; addr=0, din=0, wren=0, rden=0, busy=0, toggle_pulse=0, event_count=0, prev_bit=0, have_base=0, sample_valid=0.
- Bus outputs (addr, din, wren, rden, busy) decoded from state register only; no combinational path from start/stop/dout.
- States and bus drive:
  IDLE: addr=0, din=0, wren=0, rden=0. start=1 -> WR_PERIOD; clear event_count to 0, have_base=0.
  WR_PERIOD: addr=2'b01, din=PERIOD, wren=1 (exactly one cycle) -> WR_CTRL.
  WR_CTRL: addr=2'b00, din=CTRL_ON, wren=1 (one cycle) -> POLL.
  POLL: addr=2'b10, din=0, rden=1 every cycle; stays until stop.
  WR_STOP: addr=2'b00, din=0, wren=1 (one cycle) -> IDLE.
- stop=1 in WR_PERIOD, WR_CTRL or POLL -> WR_STOP next cycle (takes priority over normal transition). stop in IDLE or WR_STOP ignored. start outside IDLE ignored. start and stop both high in IDLE -> start wins.
- wren and rden never high in the same cycle.
- Latency: start sampled at edge N -> WR_PERIOD during N+1, WR_CTRL N+2, POLL from N+3, first dout sample at N+4.
- sample_valid = registered (state==POLL); on each cycle with sample_valid=1, b=dout[POLL_BIT]:
  have_base=0: prev_bit<=b, have_base<=1, no pulse (baseline only).
  have_base=1 and b!=prev_bit: toggle_pulse=1 that cycle (registered, visible next cycle), event_count<=event_count+1, prev_bit<=b.
  b==prev_bit: nothing.
- Sample arriving in the WR_STOP cycle (from last POLL cycle) is still evaluated.
- event_count wraps modulo 2^CNT_W (2^CNT_W-1 -> 0), no saturation; holds value in IDLE until next start.
- Both rising and falling edges count.
- Reset mid-operation: immediate return to IDLE values; no WR_STOP write issued (timer itself is reset by the same net).

Test Plan:
- Reset release, start=0 for 20 cycles -> busy=0, wren=rden=0, addr=0, event_count=0.
- start pulse at cycle N -> N+1: addr=01, din=32'h005F5E10, wren=1; N+2: addr=00, din=1, wren=1; N+3 onward: addr=10, rden=1, busy=1.
- In POLL, model dout[2]=0 for 5 cycles, then 1, 1, 0 -> exactly two toggle_pulses, each one cycle, event_count=2; baseline sample produces no pulse.
- First sampled dout[2]=1 -> no pulse; stays 1 for 10 cycles -> event_count=0.
- stop asserted during WR_CTRL -> next cycle addr=00, din=0, wren=1, then IDLE, busy=0; new start clears event_count to 0.
- CNT_W=2, drive 5 toggles -> event_count sequence 1,2,3,0,1; reset asserted mid-POLL -> all outputs zero asynchronously.
